alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station directly upstream of the ALU in the superscalar back end.
- Accepts decoded ALU ops from dispatch and holds them until both source operands are available. Operands arrive either at dispatch or via CDB broadcast.
- Issues the oldest ready op through a registered output stage carrying operand1, operand2, shamt, opSel and dest tag.
- Supports pipeline flush.

Parameters:
- DEPTH, 4, number of entries (2..8).
- DATA_W, 32, operand width.
- TAG_W, 4, ROB/physical tag width.
- OP_W, 4, ALU opSel width. Encoding passed through untouched.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discard all entries and the output stage.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept.
- disp_opSel  in  OP_W  ALU operation.
- disp_shamt  in  5  shift amount.
- disp_dest_tag  in  TAG_W  result tag.
- disp_src1_rdy, disp_src2_rdy  in  1 each  source value already valid.
- disp_src1_val, disp_src2_val  in  DATA_W each  source value when rdy.
- disp_src1_tag, disp_src2_tag  in  TAG_W each  producer tag when not rdy.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- issue_valid  out  1  output stage holds an op.
- issue_ready  in  1  ALU stage accepts.
- issue_operand1, issue_operand2  out  DATA_W each  ALU operands.
- issue_shamt  out  5  shift amount.
- issue_opSel  out  OP_W  operation.
- issue_dest_tag  out  TAG_W  result tag.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst==0 at edge):
  - All entry valid bits cleared; count=0; issue_valid=0.
  - issue_operand1/2, issue_shamt, issue_opSel, issue_dest_tag = 0.
  - disp_ready=1 after reset.
- Priority: reset > flush > normal operation.
- Flush:
  - Clears all entries and issue_valid in one edge; count=0.
  - Same-cycle dispatch is dropped.
  - Output data registers hold their old values.
- Storage: collapsing queue. Index 0 is the oldest entry.
- Dispatch accept:
  - Accepted when disp_valid && disp_ready.
  - disp_ready = (count < DEPTH), computed from current state only. A same-cycle issue does not free a slot for dispatch.
  - The new entry is written at index count-minus-removed (0 or 1).
- Dispatch-time CDB capture:
  - Applies to a non-ready source whose tag equals cdb_tag while cdb_valid.
  - The source is written ready with cdb_data.
- Wakeup:
  - Every valid entry with a non-ready source whose tag equals cdb_tag while cdb_valid sets that source ready and latches cdb_data.
  - Both sources may wake in the same cycle.
- Select:
  - Candidate = lowest-index valid entry with both sources ready, using the registered ready bits.
  - An entry woken in cycle N becomes selectable in N+1.
- Output stage:
  - Loads when a candidate exists and (!issue_valid || issue_ready).
  - The loaded entry is removed; higher entries shift down by one.
  - If there is no candidate and issue_ready && issue_valid, issue_valid falls to 0.
- Hold:
  - While issue_valid && !issue_ready, all issue_* outputs are stable.
  - No entry is removed while holding.
- Latency:
  - A dispatch accepted at edge E0 with both sources ready gives issue_valid=1 after edge E1, provided it is the oldest ready entry and the output stage is free.
  - Throughput is 1 issue/cycle when the ALU is always ready.
- Count update: count(next) = count + accepted − loaded.
- Occupancy boundaries:
  - Full: disp_ready=0; disp_valid is ignored.
  - Empty: no load; issue_valid drains.
- Data path: no arithmetic. Values and tags pass through bit-exact.

Optional Feature:
- Macro: ALU_RS_BYPASS_EN.
- Defined: a dispatched op with both sources ready at dispatch (including dispatch-time CDB capture) loads straight into the output stage at E0. Conditions:
  - no queued candidate exists;
  - the output stage is free or being consumed;
  - no entry is written in that case.
  - Dispatch-to-issue_valid then takes one edge.
- Undefined: every op passes through an entry, with two-edge minimum latency.

Test Plan:
- Reset, then dispatch ADD with src1=0x5, src2=0x7 both ready and dest_tag=3; issue_ready=1 -> issue_valid=1 after edge E1 with operand1=5, operand2=7, opSel=0000, dest_tag=3; count returns to 0.
- Dispatch op A waiting on tag 9, then op B fully ready -> B issues first. Then cdb_valid with tag=9, data=0xDEADBEEF -> A issues the following cycle with operand1=0xDEADBEEF.
- Fill 4 entries all waiting on tag 2 -> disp_ready=0 and count=4; a fifth disp_valid is not stored. Broadcast tag 2 -> entries issue in dispatch order over 4 cycles with issue_ready=1.
- issue_ready=0 for 3 cycles with an op in the output stage -> all issue_* outputs stable and count unchanged; issue_ready=1 -> next oldest ready op loads on the same edge.
- Assert flush with 3 entries and issue_valid=1 -> next cycle count=0, issue_valid=0, disp_ready=1. Assert rst=0 mid-operation -> same result, and all issue_* outputs read 0.
- Dispatch with src2 non-ready, tag 5, while cdb_valid with tag 5, data=0x10 -> entry is stored ready; SLL with shamt=4 issues operand2=0x10, shamt=4. With ALU_RS_BYPASS_EN it issues after edge E0.

Source files
------------

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Purpose  : Reservation station in front of the ALU. Holds decoded ALU ops
//            until both source operands are available (at dispatch or via
//            CDB broadcast), then issues the oldest ready op through a
//            registered output stage. Storage is a collapsing queue with
//            index 0 holding the oldest entry.
// Ports    : clk, rst (sync, active-low), flush
//            disp_*   : dispatch request / operands / tags, disp_ready back
//            cdb_*    : result broadcast used for wakeup and capture
//            issue_*  : registered output stage with valid/ready handshake
//            count    : number of occupied entries
// Options  : `define ALU_RS_BYPASS_EN lets a fully-ready dispatch load the
//            output stage directly when no queued op is ready and the stage
//            is free or draining.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    // dispatch
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_opSel,
    input  logic [4:0]                 disp_shamt,
    input  logic [TAG_W-1:0]           disp_dest_tag,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [DATA_W-1:0]          disp_src1_val,
    input  logic [DATA_W-1:0]          disp_src2_val,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    // common data bus
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    // issue
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [DATA_W-1:0]          issue_operand1,
    output logic [DATA_W-1:0]          issue_operand2,
    output logic [4:0]                 issue_shamt,
    output logic [OP_W-1:0]            issue_opSel,
    output logic [TAG_W-1:0]           issue_dest_tag,
    // occupancy
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    // ------------------------------------------------------------------------
    // Entry storage. Validity is implied by position: entry i is valid when
    // i < r_count, so no per-entry valid bit is kept.
    // ------------------------------------------------------------------------
    logic [OP_W-1:0]    r_op    [DEPTH];
    logic [4:0]         r_shamt [DEPTH];
    logic [TAG_W-1:0]   r_dest  [DEPTH];
    logic               r_s1rdy [DEPTH];
    logic [DATA_W-1:0]  r_s1val [DEPTH];
    logic [TAG_W-1:0]   r_s1tag [DEPTH];
    logic               r_s2rdy [DEPTH];
    logic [DATA_W-1:0]  r_s2val [DEPTH];
    logic [TAG_W-1:0]   r_s2tag [DEPTH];
    logic [c_cnt_w-1:0] r_count;

    // Output stage registers
    logic               r_iss_vld;
    logic [DATA_W-1:0]  r_iss_op1;
    logic [DATA_W-1:0]  r_iss_op2;
    logic [4:0]         r_iss_shamt;
    logic [OP_W-1:0]    r_iss_opsel;
    logic [TAG_W-1:0]   r_iss_dest;

    // Source state after this cycle's CDB wakeup
    logic               w_wk_s1rdy [DEPTH];
    logic [DATA_W-1:0]  w_wk_s1val [DEPTH];
    logic               w_wk_s2rdy [DEPTH];
    logic [DATA_W-1:0]  w_wk_s2val [DEPTH];

    // Incoming entry with dispatch-time CDB capture applied
    logic               w_new_s1rdy;
    logic [DATA_W-1:0]  w_new_s1val;
    logic               w_new_s2rdy;
    logic [DATA_W-1:0]  w_new_s2val;

    // Select result
    logic               w_cand;
    logic [c_idx_w-1:0] w_cand_idx;
    logic [DATA_W-1:0]  w_cand_op1;
    logic [DATA_W-1:0]  w_cand_op2;
    logic [4:0]         w_cand_shamt;
    logic [OP_W-1:0]    w_cand_opsel;
    logic [TAG_W-1:0]   w_cand_dest;

    logic               w_accept;
    logic               w_stage_free;
    logic               w_load;
    logic               w_bypass;
    logic               w_wr_en;
    logic [c_cnt_w-1:0] w_wr_pos;

    // ------------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------------
    // Readiness depends only on current occupancy; an issue in the same cycle
    // does not open a slot for dispatch.
    assign disp_ready   = (r_count < c_cnt_w'(DEPTH));
    assign w_accept     = disp_valid && disp_ready;
    assign w_stage_free = !r_iss_vld || issue_ready;
    assign w_load       = w_cand && w_stage_free;

    assign w_new_s1rdy  = disp_src1_rdy || (cdb_valid && (disp_src1_tag == cdb_tag));
    assign w_new_s1val  = disp_src1_rdy ? disp_src1_val : cdb_data;
    assign w_new_s2rdy  = disp_src2_rdy || (cdb_valid && (disp_src2_tag == cdb_tag));
    assign w_new_s2val  = disp_src2_rdy ? disp_src2_val : cdb_data;

`ifdef ALU_RS_BYPASS_EN
    // Queued ready ops always win over the bypass so issue order stays
    // oldest-first among ready ops.
    assign w_bypass = w_accept && w_new_s1rdy && w_new_s2rdy && !w_cand && w_stage_free;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_wr_en  = w_accept && !w_bypass;
    // The new entry lands just past the last survivor after the collapse.
    assign w_wr_pos = r_count - c_cnt_w'(w_load);

    // ------------------------------------------------------------------------
    // Select: lowest-index valid entry whose registered ready bits are both
    // set. Wakeups of this cycle are deliberately not visible here.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cand       = 1'b0;
        w_cand_idx   = '0;
        w_cand_op1   = '0;
        w_cand_op2   = '0;
        w_cand_shamt = '0;
        w_cand_opsel = '0;
        w_cand_dest  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_cand && (c_cnt_w'(i) < r_count) && r_s1rdy[i] && r_s2rdy[i]) begin
                w_cand       = 1'b1;
                w_cand_idx   = c_idx_w'(i);
                w_cand_op1   = r_s1val[i];
                w_cand_op2   = r_s2val[i];
                w_cand_shamt = r_shamt[i];
                w_cand_opsel = r_op[i];
                w_cand_dest  = r_dest[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-entry wakeup, collapse and write
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            // Neighbour that slides into this slot when an older entry leaves.
            localparam int c_up = (i < DEPTH-1) ? i + 1 : i;

            logic w_hit1;
            logic w_hit2;
            logic w_take_up;
            logic w_wr;

            assign w_hit1 = !r_s1rdy[i] && cdb_valid && (r_s1tag[i] == cdb_tag);
            assign w_hit2 = !r_s2rdy[i] && cdb_valid && (r_s2tag[i] == cdb_tag);

            assign w_wk_s1rdy[i] = r_s1rdy[i] || w_hit1;
            assign w_wk_s1val[i] = w_hit1 ? cdb_data : r_s1val[i];
            assign w_wk_s2rdy[i] = r_s2rdy[i] || w_hit2;
            assign w_wk_s2val[i] = w_hit2 ? cdb_data : r_s2val[i];

            assign w_take_up = w_load && (c_idx_w'(i) >= w_cand_idx);
            assign w_wr      = w_wr_en && (w_wr_pos == c_cnt_w'(i));

            // Contents of slots at or above r_count are don't-care, so these
            // registers need no reset or flush clearing.
            always_ff @(posedge clk) begin
                if (w_wr) begin
                    r_op[i]    <= disp_opSel;
                    r_shamt[i] <= disp_shamt;
                    r_dest[i]  <= disp_dest_tag;
                    r_s1rdy[i] <= w_new_s1rdy;
                    r_s1val[i] <= w_new_s1val;
                    r_s1tag[i] <= disp_src1_tag;
                    r_s2rdy[i] <= w_new_s2rdy;
                    r_s2val[i] <= w_new_s2val;
                    r_s2tag[i] <= disp_src2_tag;
                end else if (w_take_up) begin
                    r_op[i]    <= r_op[c_up];
                    r_shamt[i] <= r_shamt[c_up];
                    r_dest[i]  <= r_dest[c_up];
                    r_s1rdy[i] <= w_wk_s1rdy[c_up];
                    r_s1val[i] <= w_wk_s1val[c_up];
                    r_s1tag[i] <= r_s1tag[c_up];
                    r_s2rdy[i] <= w_wk_s2rdy[c_up];
                    r_s2val[i] <= w_wk_s2val[c_up];
                    r_s2tag[i] <= r_s2tag[c_up];
                end else begin
                    r_s1rdy[i] <= w_wk_s1rdy[i];
                    r_s1val[i] <= w_wk_s1val[i];
                    r_s2rdy[i] <= w_wk_s2rdy[i];
                    r_s2val[i] <= w_wk_s2val[i];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Occupancy and output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_iss_vld   <= 1'b0;
            r_iss_op1   <= '0;
            r_iss_op2   <= '0;
            r_iss_shamt <= '0;
            r_iss_opsel <= '0;
            r_iss_dest  <= '0;
        end else if (flush) begin
            // Output data deliberately holds; only the valid bit drops.
            r_count   <= '0;
            r_iss_vld <= 1'b0;
        end else begin
            r_count <= r_count + c_cnt_w'(w_wr_en) - c_cnt_w'(w_load);
            if (w_load) begin
                r_iss_vld   <= 1'b1;
                r_iss_op1   <= w_cand_op1;
                r_iss_op2   <= w_cand_op2;
                r_iss_shamt <= w_cand_shamt;
                r_iss_opsel <= w_cand_opsel;
                r_iss_dest  <= w_cand_dest;
            end else if (w_bypass) begin
                r_iss_vld   <= 1'b1;
                r_iss_op1   <= w_new_s1val;
                r_iss_op2   <= w_new_s2val;
                r_iss_shamt <= disp_shamt;
                r_iss_opsel <= disp_opSel;
                r_iss_dest  <= disp_dest_tag;
            end else if (issue_ready) begin
                r_iss_vld <= 1'b0;
            end
        end
    end

    assign issue_valid    = r_iss_vld;
    assign issue_operand1 = r_iss_op1;
    assign issue_operand2 = r_iss_op2;
    assign issue_shamt    = r_iss_shamt;
    assign issue_opSel    = r_iss_opsel;
    assign issue_dest_tag = r_iss_dest;
    assign count          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Purpose  : Self-checking bench for alu_rs. A queue-based reference model
//            tracks the station every clock; directed sequences pin literal
//            values, then randomized traffic is compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_opSel;
    logic [4:0]        disp_shamt;
    logic [TAG_W-1:0]  disp_dest_tag;
    logic              disp_src1_rdy;
    logic              disp_src2_rdy;
    logic [DATA_W-1:0] disp_src1_val;
    logic [DATA_W-1:0] disp_src2_val;
    logic [TAG_W-1:0]  disp_src1_tag;
    logic [TAG_W-1:0]  disp_src2_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_operand1;
    logic [DATA_W-1:0] issue_operand2;
    logic [4:0]        issue_shamt;
    logic [OP_W-1:0]   issue_opSel;
    logic [TAG_W-1:0]  issue_dest_tag;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    alu_rs #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .TAG_W (TAG_W),
        .OP_W  (OP_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_opSel    (disp_opSel),
        .disp_shamt    (disp_shamt),
        .disp_dest_tag (disp_dest_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src1_val (disp_src1_val),
        .disp_src2_val (disp_src2_val),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_operand1(issue_operand1),
        .issue_operand2(issue_operand2),
        .issue_shamt   (issue_shamt),
        .issue_opSel   (issue_opSel),
        .issue_dest_tag(issue_dest_tag),
        .count         (count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a plain queue of pending ops plus the output stage.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [OP_W-1:0]   op;
        logic [4:0]        sh;
        logic [TAG_W-1:0]  dt;
        logic              r1;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  t1;
        logic              r2;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  t2;
    } ent_t;

    ent_t              mq[$];
    logic              m_ov;
    logic [DATA_W-1:0] m_o1;
    logic [DATA_W-1:0] m_o2;
    logic [4:0]        m_sh;
    logic [OP_W-1:0]   m_op;
    logic [TAG_W-1:0]  m_dt;

    always @(posedge clk) begin : model
        ent_t ne;
        ent_t e;
        int   cand;
        bit   acc;
        bit   ld;
        bit   byp;
        if (!rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_o1 = '0;
            m_o2 = '0;
            m_sh = '0;
            m_op = '0;
            m_dt = '0;
        end else if (flush) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            acc  = disp_valid && (mq.size() < DEPTH);
            cand = -1;
            foreach (mq[i]) if (cand < 0 && mq[i].r1 && mq[i].r2) cand = i;
            ld = (cand >= 0) && (!m_ov || issue_ready);

            ne.op = disp_opSel;
            ne.sh = disp_shamt;
            ne.dt = disp_dest_tag;
            ne.t1 = disp_src1_tag;
            ne.t2 = disp_src2_tag;
            ne.r1 = disp_src1_rdy || (cdb_valid && disp_src1_tag == cdb_tag);
            ne.v1 = disp_src1_rdy ? disp_src1_val : cdb_data;
            ne.r2 = disp_src2_rdy || (cdb_valid && disp_src2_tag == cdb_tag);
            ne.v2 = disp_src2_rdy ? disp_src2_val : cdb_data;

            byp = 1'b0;
`ifdef ALU_RS_BYPASS_EN
            byp = acc && ne.r1 && ne.r2 && (cand < 0) && (!m_ov || issue_ready);
`endif
            if (ld) begin
                m_ov = 1'b1;
                m_o1 = mq[cand].v1;
                m_o2 = mq[cand].v2;
                m_sh = mq[cand].sh;
                m_op = mq[cand].op;
                m_dt = mq[cand].dt;
                mq.delete(cand);
            end else if (byp) begin
                m_ov = 1'b1;
                m_o1 = ne.v1;
                m_o2 = ne.v2;
                m_sh = ne.sh;
                m_op = ne.op;
                m_dt = ne.dt;
            end else if (issue_ready) begin
                m_ov = 1'b0;
            end

            foreach (mq[i]) begin
                e = mq[i];
                if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
                if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
                mq[i] = e;
            end
            if (acc && !byp) mq.push_back(ne);
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_issue_valid", 32'(issue_valid),    32'(m_ov));
            chk("m_operand1",    issue_operand1,      m_o1);
            chk("m_operand2",    issue_operand2,      m_o2);
            chk("m_shamt",       32'(issue_shamt),    32'(m_sh));
            chk("m_opSel",       32'(issue_opSel),    32'(m_op));
            chk("m_dest_tag",    32'(issue_dest_tag), 32'(m_dt));
            chk("m_count",       32'(count),          32'(mq.size()));
            chk("m_disp_ready",  32'(disp_ready),     32'(mq.size() < DEPTH));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [4:0] sh, input logic [TAG_W-1:0] dt,
                        input logic r1, input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] t1,
                        input logic r2, input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] t2);
        disp_valid    = 1'b1;
        disp_opSel    = op;
        disp_shamt    = sh;
        disp_dest_tag = dt;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src1_tag = t1;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
        disp_src2_tag = t2;
    endtask

    task automatic zero_outputs_chk(input string pfx);
        chk({pfx, "_valid"},    32'(issue_valid),    32'd0);
        chk({pfx, "_op1"},      issue_operand1,      32'd0);
        chk({pfx, "_op2"},      issue_operand2,      32'd0);
        chk({pfx, "_shamt"},    32'(issue_shamt),    32'd0);
        chk({pfx, "_opSel"},    32'(issue_opSel),    32'd0);
        chk({pfx, "_dest"},     32'(issue_dest_tag), 32'd0);
        chk({pfx, "_count"},    32'(count),          32'd0);
        chk({pfx, "_dready"},   32'(disp_ready),     32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        disp_valid = 1'b0; disp_opSel = '0; disp_shamt = '0; disp_dest_tag = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_src1_val = '0; disp_src2_val = '0;
        disp_src1_tag = '0; disp_src2_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

        tick(); tick();
        chk_en = 1'b1;
        zero_outputs_chk("reset");
        rst = 1'b1;
        issue_ready = 1'b1;

        // ---- T1: fully ready ADD ----
        disp(4'h0, 5'd0, 4'd3, 1'b1, 32'h5, 4'd0, 1'b1, 32'h7, 4'd0);
        tick();
        disp_valid = 1'b0;
`ifndef ALU_RS_BYPASS_EN
        chk("t1_count_e0", 32'(count), 32'd1);
        chk("t1_valid_e0", 32'(issue_valid), 32'd0);
        tick();
`endif
        chk("t1_valid", 32'(issue_valid), 32'd1);
        chk("t1_op1", issue_operand1, 32'h5);
        chk("t1_op2", issue_operand2, 32'h7);
        chk("t1_opSel", 32'(issue_opSel), 32'h0);
        chk("t1_dest", 32'(issue_dest_tag), 32'd3);
        chk("t1_count", 32'(count), 32'd0);
        tick();
        chk("t1_drain", 32'(issue_valid), 32'd0);

        // ---- T2: younger ready op overtakes a waiting one ----
        disp(4'h1, 5'd0, 4'd1, 1'b0, 32'h0, 4'd9, 1'b1, 32'h1, 4'd0);
        tick();
        disp(4'h2, 5'd0, 4'd2, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0);
        tick();
        disp_valid = 1'b0;
`ifndef ALU_RS_BYPASS_EN
        tick();
`endif
        chk("t2_b_valid", 32'(issue_valid), 32'd1);
        chk("t2_b_dest", 32'(issue_dest_tag), 32'd2);
        chk("t2_b_op1", issue_operand1, 32'h11);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'hDEADBEEF;
        tick();
        cdb_valid = 1'b0;
        chk("t2_gap", 32'(issue_valid), 32'd0);
        tick();
        chk("t2_a_valid", 32'(issue_valid), 32'd1);
        chk("t2_a_dest", 32'(issue_dest_tag), 32'd1);
        chk("t2_a_op1", issue_operand1, 32'hDEADBEEF);
        chk("t2_a_op2", issue_operand2, 32'h1);
        tick();

        // ---- T3: fill, reject when full, drain in order ----
        for (int k = 0; k < 4; k++) begin
            disp(OP_W'(k), 5'd0, TAG_W'(4 + k), 1'b0, 32'h0, 4'd2, 1'b1, 32'h100 + 32'(k), 4'd0);
            tick();
        end
        disp_valid = 1'b0;
        chk("t3_full_count", 32'(count), 32'd4);
        chk("t3_full_ready", 32'(disp_ready), 32'd0);
        disp(4'hF, 5'd0, 4'd8, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        tick();
        disp_valid = 1'b0;
        chk("t3_reject_count", 32'(count), 32'd4);
        chk("t3_reject_valid", 32'(issue_valid), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hC0DE;
        tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_valid", 32'(issue_valid), 32'd1);
            chk("t3_dest", 32'(issue_dest_tag), 32'(4 + k));
            chk("t3_op1", issue_operand1, 32'hC0DE);
            chk("t3_op2", issue_operand2, 32'h100 + 32'(k));
            chk("t3_count", 32'(count), 32'(3 - k));
        end
        tick();
        chk("t3_drain", 32'(issue_valid), 32'd0);

        // ---- T4: hold under back-pressure ----
        issue_ready = 1'b0;
        disp(4'h3, 5'd1, 4'd10, 1'b1, 32'hA, 4'd0, 1'b1, 32'hB, 4'd0);
        tick();
        disp(4'h3, 5'd2, 4'd11, 1'b1, 32'hC, 4'd0, 1'b1, 32'hD, 4'd0);
        tick();
        disp_valid = 1'b0;
        chk("t4_count", 32'(count), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_valid", 32'(issue_valid), 32'd1);
            chk("t4_hold_dest", 32'(issue_dest_tag), 32'd10);
            chk("t4_hold_op1", issue_operand1, 32'hA);
            chk("t4_hold_op2", issue_operand2, 32'hB);
            chk("t4_hold_shamt", 32'(issue_shamt), 32'd1);
            chk("t4_hold_count", 32'(count), 32'd1);
        end
        issue_ready = 1'b1;
        tick();
        chk("t4_next_dest", 32'(issue_dest_tag), 32'd11);
        chk("t4_next_op1", issue_operand1, 32'hC);
        chk("t4_next_shamt", 32'(issue_shamt), 32'd2);
        chk("t4_next_count", 32'(count), 32'd0);
        tick();

        // ---- T5: flush, then reset mid-operation ----
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'h0, 5'd0, TAG_W'(k + 12), 1'b1, 32'h200 + 32'(k), 4'd0, 1'b1, 32'h0, 4'd0);
            tick();
        end
        disp_valid = 1'b0;
        chk("t5_pre_count", 32'(count), 32'd3);
        chk("t5_pre_valid", 32'(issue_valid), 32'd1);
        flush = 1'b1;
        disp(4'h0, 5'd0, 4'd7, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        chk("t5_fl_count", 32'(count), 32'd0);
        chk("t5_fl_valid", 32'(issue_valid), 32'd0);
        chk("t5_fl_ready", 32'(disp_ready), 32'd1);
        chk("t5_fl_op1_hold", issue_operand1, 32'h200);
        chk("t5_fl_dest_hold", 32'(issue_dest_tag), 32'd12);
        for (int k = 0; k < 4; k++) begin
            disp(4'h5, 5'd3, TAG_W'(k), 1'b1, 32'h300 + 32'(k), 4'd0, 1'b1, 32'h9, 4'd0);
            tick();
        end
        disp_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        zero_outputs_chk("t5_rst");
        issue_ready = 1'b1;

        // ---- T6: dispatch-time CDB capture on src2 ----
        disp(4'h1, 5'd4, 4'd12, 1'b1, 32'h3, 4'd0, 1'b0, 32'h0, 4'd5);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h10;
        tick();
        disp_valid = 1'b0;
        cdb_valid = 1'b0;
`ifndef ALU_RS_BYPASS_EN
        chk("t6_count_e0", 32'(count), 32'd1);
        tick();
`endif
        chk("t6_valid", 32'(issue_valid), 32'd1);
        chk("t6_op2", issue_operand2, 32'h10);
        chk("t6_shamt", 32'(issue_shamt), 32'd4);
        chk("t6_op1", issue_operand1, 32'h3);
        chk("t6_dest", 32'(issue_dest_tag), 32'd12);
        tick();

        // ---- Randomized traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            disp_valid    = ($urandom_range(0, 1) == 1);
            disp_opSel    = OP_W'($urandom);
            disp_shamt    = 5'($urandom);
            disp_dest_tag = TAG_W'($urandom);
            disp_src1_rdy = ($urandom_range(0, 2) != 0);
            disp_src2_rdy = ($urandom_range(0, 2) != 0);
            disp_src1_val = $urandom;
            disp_src2_val = $urandom;
            disp_src1_tag = TAG_W'($urandom_range(0, 7));
            disp_src2_tag = TAG_W'($urandom_range(0, 7));
            cdb_valid     = ($urandom_range(0, 1) == 1);
            cdb_tag       = TAG_W'($urandom_range(0, 7));
            cdb_data      = $urandom;
            issue_ready   = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 49) == 0);
            rst           = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
